// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester, response and multiplier-core signals of the
// shared-multiplier arbiter, bundled into one interface.
//   slave  : the arbiter's view (consumes requests, drives the core).
//   master : the environment's view (clients, response consumer, core).
interface mult_share_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    // Requester side: one valid/ready pair and one operand slice per client
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;

    // Shared response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_p;
    logic              rsp_err;

    // Multiplier core
    logic              mul_start;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_done;
    logic [2*N-1:0]    mul_p;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin arbiter that shares one multi-cycle signed
// multiplier core among NREQ requesters. One operation is in flight at a time:
// grant in IDLE, pulse the core in LAUNCH, wait for completion in WAIT, hold the
// tagged 2N-bit product in RESP until the consumer takes it.
// Optional build macro MULT_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles
// that aborts with rsp_err=1 and rsp_p=0; without it rsp_err is tied low.
module mult_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  io_bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned PW  = 2 * N;

    if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("mult_share_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_rsp_id;
    logic [N-1:0]    r_mul_a;
    logic [N-1:0]    r_mul_b;
    logic [PW-1:0]   r_rsp_p;

    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic [NREQ-1:0] w_onehot;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;

    logic            w_accept;
    logic            w_capture;
    logic            w_abort;
    logic            w_rsp_fire;
    logic            w_timeout;

    // Round-robin search: first valid requester strictly after the pointer, with wrap
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!w_any && (i == (int'(r_ptr) + k) % int'(NREQ)) && io_bus.req_valid[i]) begin
                    w_any = 1'b1;
                    w_win = IDW'(i);
                end
            end
        end
    end

    // Winner decode: one-hot grant vector and operand slice select
    always_comb begin
        w_onehot = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_win == IDW'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_a     = io_bus.req_a[i*N +: N];
                w_sel_b     = io_bus.req_b[i*N +: N];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        w_rsp_fire   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_state_next = StLaunch;
                end
            end
            StLaunch: begin
                w_state_next = StWait;
            end
            StWait: begin
                // Completion wins over a watchdog expiry in the same cycle
                if (io_bus.mul_done) begin
                    w_capture    = 1'b1;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (io_bus.rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Datapath: operand/ID latch on accept, product capture, pointer update on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= IDW'(NREQ - 1);
            r_rsp_id <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_rsp_p  <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a  <= w_sel_a;
                r_mul_b  <= w_sel_b;
                r_rsp_id <= w_win;
            end
            if (w_capture) begin
                r_rsp_p <= io_bus.mul_p;
            end else if (w_abort) begin
                r_rsp_p <= '0;
            end
            // The served requester drops to lowest priority for the next round
            if (w_rsp_fire) begin
                r_ptr <= r_rsp_id;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] r_wait_cnt;
    logic            r_rsp_err;

    // Watchdog: counts cycles spent in WAIT, cleared in every other state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != StWait) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CntW'(1);
        end
    end

    // Expires on the TIMEOUT-th WAIT cycle without completion
    assign w_timeout = (r_wait_cnt == CntW'(TIMEOUT - 1));

    // Error flag: set by an abort, cleared by a real completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= 1'b0;
        end else if (w_abort) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign io_bus.rsp_err = r_rsp_err;
`else
    assign w_timeout      = 1'b0;
    assign io_bus.rsp_err = 1'b0;
`endif

    // Grant is only shown while not in reset so a held-reset cycle never looks accepted
    assign io_bus.req_ready = (w_accept && !rst) ? w_onehot : '0;
    assign io_bus.rsp_valid = (r_state == StResp);
    assign io_bus.rsp_id    = r_rsp_id;
    assign io_bus.rsp_p     = r_rsp_p;
    assign io_bus.mul_start = (r_state == StLaunch);
    assign io_bus.mul_a     = r_mul_a;
    assign io_bus.mul_b     = r_mul_b;

endmodule
